// File: rtl/alb_seq.sv
// alb_seq: multi-word sequencer around the 10-bit alb ALU.
// Runs one WORDS*10-bit operation through a single alb, one slice per cycle,
// LSW first, chaining carry/borrow between slices.
// Optional feature macro: ALB_SEQ_ABORT_EN adds an 'abort' input that cancels
// an operation while it is running.

// 10-bit ALU slice: 00 ~R|S, 01 R+S+CI, 10 ~(R^S), 11 R-S-1+CI (CO = borrow).
module alb (
  input  logic [9:0] r,
  input  logic [9:0] s,
  input  logic [1:0] sel,
  input  logic       ci,
  output logic [9:0] f,
  output logic       co
);

  logic [10:0] sum;
  logic [10:0] diff;

  // Combinational slice result; the subtract path keeps one extra bit
  // whose value after the wrap is the borrow-out.
  always_comb begin
    sum  = {1'b0, r} + {1'b0, s} + {10'd0, ci};
    diff = {1'b0, r} - {1'b0, s} - 11'd1 + {10'd0, ci};
    f    = '0;
    co   = 1'b0;
    case (sel)
      2'b00: f = ~r | s;
      2'b01: {co, f} = sum;
      2'b10: f = ~(r ^ s);
      2'b11: begin
        f  = diff[9:0];
        co = diff[10];
      end
      default: f = '0;
    endcase
  end

endmodule

module alb_seq #(
  parameter int unsigned WORDS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [10*WORDS-1:0]   req_a,
  input  logic [10*WORDS-1:0]   req_b,
  input  logic                  req_ci,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [10*WORDS-1:0]   rsp_f,
  output logic                  rsp_co,
  output logic                  rsp_vo,
  output logic                  rsp_no,
  output logic                  rsp_zo
`ifdef ALB_SEQ_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int unsigned W = 10 * WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_n;

  logic [1:0]   op_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         cin_r;
  logic [2:0]   k;

  logic [9:0]   alb_r;
  logic [9:0]   alb_s;
  logic [9:0]   alb_f;
  logic         alb_co;
  logic [W-1:0] f_full;
  logic         last;
  logic         abort_i;
  int unsigned  base;

`ifdef ALB_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  alb u_alb (
    .r   (alb_r),
    .s   (alb_s),
    .sel (op_r),
    .ci  (cin_r),
    .f   (alb_f),
    .co  (alb_co)
  );

  // Select the current slice and merge its result into the wide word.
  always_comb begin
    base               = 32'(k) * 32'd10;
    alb_r              = a_r[base +: 10];
    alb_s              = b_r[base +: 10];
    f_full             = rsp_f;
    f_full[base +: 10] = alb_f;
    last               = (k == 3'(WORDS - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_valid && req_ready) state_n = RUN;
      RUN: begin
        if (abort_i)   state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE: if (rsp_valid && rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are registered: req_ready follows the state we are
  // entering, and rsp_valid rises one cycle after reaching DONE so the
  // response appears WORDS+1 edges after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= (state_n == IDLE);
      rsp_valid <= (state == DONE) && !(rsp_valid && rsp_ready);
    end
  end

  // Operand capture, slice stepping, carry chaining and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      cin_r  <= 1'b0;
      k      <= '0;
      rsp_f  <= '0;
      rsp_co <= 1'b0;
      rsp_vo <= 1'b0;
      rsp_no <= 1'b0;
      rsp_zo <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_r  <= req_op;
            a_r   <= req_a;
            b_r   <= req_b;
            cin_r <= req_ci;
            k     <= '0;
          end
        end
        RUN: begin
          if (!abort_i) begin
            rsp_f <= f_full;
            case (op_r)
              2'b01:   cin_r <= alb_co;
              2'b11:   cin_r <= ~alb_co;
              default: cin_r <= cin_r;
            endcase
            if (last) begin
              rsp_co <= op_r[0] ? alb_co : 1'b0;
              rsp_no <= f_full[W-1];
              rsp_zo <= (f_full == '0);
              case (op_r)
                2'b01:   rsp_vo <= (a_r[W-1] == b_r[W-1]) && (f_full[W-1] != a_r[W-1]);
                2'b11:   rsp_vo <= (a_r[W-1] != b_r[W-1]) && (f_full[W-1] != a_r[W-1]);
                default: rsp_vo <= 1'b0;
              endcase
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
